// File: rtl/nibble_pkg.sv
// Shared nibble-swap definitions, used by both the transmit and receive ends of the link.
package nibble_pkg;

  localparam int NIB_DATA_W     = 8;
  localparam int NIB_FIFO_DEPTH = 4;
  localparam int NIB_CNT_W      = 16;

  function automatic logic [NIB_DATA_W-1:0] nib_swap(input logic [NIB_DATA_W-1:0] b);
    return {b[NIB_DATA_W/2-1:0], b[NIB_DATA_W-1:NIB_DATA_W/2]};
  endfunction

endpackage

// File: rtl/nibble_fifo.sv
// Registered FIFO with output at the head entry. Data is visible one cycle after a push, with no bypass.
// Backpressure: in_ready drops when full, and a pop while full frees space only on the next cycle.
module nibble_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  assign in_ready  = (level != LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/nibble_unswap_buffer.sv
// Restores the nibble order of each byte whose flag is set, buffers it, and counts delivered bytes.
// Latency is 1 cycle from push to out_valid; valid/ready backpressure is applied on both sides via the FIFO.
module nibble_unswap_buffer
  import nibble_pkg::*;
#(
  parameter int DEPTH  = NIB_FIFO_DEPTH,
  parameter int DATA_W = NIB_DATA_W,
  parameter int CNT_W  = NIB_CNT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         unswap_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [CNT_W-1:0]             xfer_cnt
);

  logic [DATA_W-1:0] swapped;
  logic [DATA_W-1:0] wr_data;

  // The shared function covers the default byte width; other widths use the same mapping inline.
  generate
    if (DATA_W == NIB_DATA_W) begin : g_pkg_swap
      always_comb swapped = nib_swap(in_data);
    end else begin : g_local_swap
      always_comb swapped = {in_data[DATA_W/2-1:0], in_data[DATA_W-1:DATA_W/2]};
    end
  endgenerate

  assign wr_data = unswap_en ? swapped : in_data;

  nibble_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (wr_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule
